// File: rtl/pingpong_width_conv_if.sv
// Stream bundle for the ping-pong width converter.
// Wide words enter on in_*, narrow slices leave on out_*.
interface pingpong_width_conv_if #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );
endinterface

// File: rtl/pingpong_width_conv.sv
// Two-bank ping-pong buffer that splits IN_W-bit words into
// RATIO OUT_W-bit slices, one bank filling while the other drains.
module pingpong_width_conv #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pingpong_width_conv_if.slave bus,
    output logic [1:0]           occupancy
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_cfg
        $error("pingpong_width_conv: IN_W must be a multiple of OUT_W with RATIO >= 2");
    end

    logic [IN_W-1:0] bank0;
    logic [IN_W-1:0] bank1;
    logic [1:0]      full;
    logic            wr_sel;
    logic            rd_sel;
    logic [CW-1:0]   cnt;

    logic                        wr_fire;
    logic                        rd_fire;
    logic [IN_W-1:0]             rd_bank;
    logic [RATIO-1:0][OUT_W-1:0] slices;
    logic [CW-1:0]               idx;

    // Ready depends only on flag registers, never on out_ready.
    assign bus.in_ready  = ~full[wr_sel];
    assign bus.out_valid = full[rd_sel];
    assign bus.out_last  = full[rd_sel] && (cnt == LAST);

    assign wr_fire = bus.in_valid && ~full[wr_sel];
    assign rd_fire = full[rd_sel] && bus.out_ready;

    assign rd_bank = rd_sel ? bank1 : bank0;
    assign slices  = rd_bank;
    assign idx     = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;

    assign bus.out_data = slices[idx];
    assign occupancy    = {1'b0, full[0]} + {1'b0, full[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0  <= '0;
            bank1  <= '0;
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            cnt    <= '0;
        end else if (flush) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            cnt    <= '0;
        end else begin
            // Write and drain always hit different banks, so both flag
            // updates can land in the same cycle.
            if (wr_fire) begin
                if (wr_sel) bank1 <= bus.in_data;
                else        bank0 <= bus.in_data;
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (rd_fire) begin
                if (cnt == LAST) begin
                    cnt          <= '0;
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pingpong_width_conv.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus,
// each with its own queue of expected {last, slice} beats.
module tb_pingpong_width_conv;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occ0;
    logic [1:0] occ1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];

    pingpong_width_conv_if #(.IN_W(128), .OUT_W(32)) b0 ();
    pingpong_width_conv_if #(.IN_W(128), .OUT_W(32)) b1 ();

    assign b1.in_valid  = b0.in_valid;
    assign b1.in_data   = b0.in_data;
    assign b1.out_ready = b0.out_ready;

    pingpong_width_conv #(.IN_W(128), .OUT_W(32), .MSB_FIRST(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (b0.slave),
        .occupancy (occ0)
    );

    pingpong_width_conv #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (b1.slave),
        .occupancy (occ1)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] W_BASE = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] W_A    = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] W_B    = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] W_C    = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] W_D    = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [127:0] W_E    = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
    localparam logic [127:0] W_F    = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
    localparam logic [127:0] W_G    = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats: slice i of the word counted from the LSB end.
    task automatic push(input logic [127:0] w);
        logic [31:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = w[i*32 +: 32];
        for (int i = 0; i < 4; i++) begin
            q0.push_back({i == 3, s[i]});
            q1.push_back({i == 3, s[3-i]});
        end
    endtask

    task automatic send(input logic [127:0] w);
        bit done = 0;
        b0.in_valid = 1'b1;
        b0.in_data  = w;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (b0.in_ready) begin
                @(posedge clk);
                push(w);
                #1;
                done = 1;
            end
        end
        b0.in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept want accept of %0h", w);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            tick();
            t++;
        end
        chk("drain_q0_empty", 128'(q0.size()), 128'd0);
        chk("drain_q1_empty", 128'(q1.size()), 128'd0);
    endtask

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (b0.out_valid && b0.out_ready) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_bad++;
                    $display("FAIL lsb_beat: got %0h want no beat", b0.out_data);
                end else begin
                    e = q0.pop_front();
                    if ({b0.out_last, b0.out_data} !== e) begin
                        n_bad++;
                        $display("FAIL lsb_beat: got %0h want %0h",
                                 {b0.out_last, b0.out_data}, e);
                    end
                end
            end
            if (b1.out_valid && b1.out_ready) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL msb_beat: got %0h want no beat", b1.out_data);
                end else begin
                    e = q1.pop_front();
                    if ({b1.out_last, b1.out_data} !== e) begin
                        n_bad++;
                        $display("FAIL msb_beat: got %0h want %0h",
                                 {b1.out_last, b1.out_data}, e);
                    end
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_i;
        logic [31:0] held;
        b0.in_valid  = 1'b0;
        b0.in_data   = '0;
        b0.out_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset values
        #12;
        chk("rst_in_ready",  128'(b0.in_ready), 128'd1);
        chk("rst_out_valid", 128'(b0.out_valid), 128'd0);
        chk("rst_out_last",  128'(b0.out_last), 128'd0);
        chk("rst_occ",       128'(occ0), 128'd0);
        chk("rst_out_data",  128'(b0.out_data), 128'd0);
        rst_n = 1'b1;
        tick();

        // Single word, full-rate drain
        b0.out_ready = 1'b1;
        send(W_BASE);
        @(negedge clk);
        chk("latency_valid", 128'(b0.out_valid), 128'd1);
        chk("first_lsb", 128'(b0.out_data), 128'h11111111);
        chk("first_msb", 128'(b1.out_data), 128'h44444444);
        @(posedge clk);
        #1;
        tick();
        tick();
        tick();
        chk("after_word_valid0", 128'(b0.out_valid), 128'd0);
        chk("after_word_valid1", 128'(b1.out_valid), 128'd0);
        drain();

        // Both banks full, third word held off
        b0.out_ready = 1'b0;
        send(W_A);
        send(W_B);
        chk("full_occ", 128'(occ0), 128'd2);
        chk("full_in_ready", 128'(b0.in_ready), 128'd0);
        b0.in_valid = 1'b1;
        b0.in_data  = W_C;
        tick();
        tick();
        chk("c_held_in_ready", 128'(b0.in_ready), 128'd0);
        chk("c_held_occ", 128'(occ1), 128'd2);
        b0.out_ready = 1'b1;
        first_i = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ab_no_gap", 128'(b0.out_valid), 128'd1);
            if (first_i < 0 && b0.in_valid && b0.in_ready) first_i = i;
            @(posedge clk);
            if (first_i == i) push(W_C);
            #1;
            if (first_i == i) b0.in_valid = 1'b0;
        end
        b0.in_valid = 1'b0;
        chk("c_accept_cycle", 128'(first_i), 128'd4);
        drain();

        // Stalled every other cycle: slices hold while out_ready is low
        b0.out_ready = 1'b0;
        send(W_G);
        for (int i = 0; i < 8; i++) begin
            b0.out_ready = (i % 2 == 0);
            @(negedge clk);
            if (!b0.out_ready) held = b0.out_data;
            @(posedge clk);
            #1;
            if (i % 2 == 1) chk("stall_hold", 128'(b0.out_data), 128'(held));
        end
        b0.out_ready = 1'b1;
        drain();

        // Flush mid-word with another word buffered
        b0.out_ready = 1'b0;
        send(W_A);
        send(W_B);
        b0.out_ready = 1'b1;
        tick();
        tick();
        b0.out_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        q0.delete();
        q1.delete();
        #1;
        flush = 1'b0;
        chk("flush_occ", 128'(occ0), 128'd0);
        chk("flush_valid", 128'(b0.out_valid), 128'd0);
        chk("flush_in_ready", 128'(b0.in_ready), 128'd1);
        b0.out_ready = 1'b1;
        send(W_D);
        @(negedge clk);
        chk("flush_d_slice0", 128'(b0.out_data), 128'hD0D0D0D0);
        drain();

        // Async reset during the third slice
        send(W_E);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk("arst_in_ready",  128'(b0.in_ready), 128'd1);
        chk("arst_out_valid", 128'(b0.out_valid), 128'd0);
        chk("arst_out_last",  128'(b0.out_last), 128'd0);
        chk("arst_occ",       128'(occ0), 128'd0);
        chk("arst_out_data",  128'(b0.out_data), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(W_F);
        @(negedge clk);
        chk("arst_f_slice0", 128'(b0.out_data), 128'hF0F0F0F0);
        drain();
        tick();
        chk("end_valid", 128'(b0.out_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pingpong_width_conv.md
PINGPONG_WIDTH_CONV -- requirements
Module: pingpong_width_conv

Interface
REQ-001 The block SHALL have parameter IN_W, default 128, meaning the input word width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, meaning the output slice width in bits.
REQ-003 The block SHALL have parameter MSB_FIRST, default 0, where 0 emits the least-significant slice first and 1 emits the most-significant slice first.
REQ-004 The block SHALL have derived constant RATIO = IN_W/OUT_W.
REQ-005 The configuration SHALL require IN_W % OUT_W == 0 and RATIO >= 2; elaboration SHALL fail otherwise.
REQ-006 Port: clk  input  1  clock; all logic SHALL operate on its rising edge.
REQ-007 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port: flush  input  1  synchronous clear of both banks and all pointers.
REQ-009 Port: in_valid  input  1  in_data is valid.
REQ-010 Port: in_ready  output  1  the block can accept in_data this cycle.
REQ-011 Port: in_data  input  IN_W  wide input word.
REQ-012 Port: out_valid  output  1  out_data is valid.
REQ-013 Port: out_ready  input  1  the downstream consumer accepts out_data this cycle.
REQ-014 Port: out_data  output  OUT_W  current slice.
REQ-015 Port: out_last  output  1  the current slice is the final slice of its word.
REQ-016 Port: occupancy  output  2  number of full banks, 0..2.

Function
REQ-017 The block SHALL hold two IN_W-bit banks (bank0, bank1), each with a full flag, a write-select bit wr_sel, a read-select bit rd_sel, and a slice counter cnt of width clog2(RATIO).
REQ-018 in_ready SHALL be the negation of full[wr_sel], driven from registers only, with no combinational path from out_ready.
REQ-019 When in_valid && in_ready, the block SHALL load in_data into bank[wr_sel], set full[wr_sel], and toggle wr_sel at the clock edge.
REQ-020 out_valid SHALL equal full[rd_sel].
REQ-021 out_data SHALL be bank[rd_sel][idx*OUT_W +: OUT_W], where idx = cnt if MSB_FIRST=0 and idx = RATIO-1-cnt if MSB_FIRST=1.
REQ-022 out_last SHALL be out_valid && (cnt == RATIO-1).
REQ-023 On each out_valid && out_ready the block SHALL increment cnt.
REQ-024 On a transfer with cnt == RATIO-1, the block SHALL clear cnt to 0, clear full[rd_sel], and toggle rd_sel.
REQ-025 When out_valid && !out_ready, out_data, out_last and cnt SHALL hold stable.
REQ-026 A write to one bank and a read or drain of the other bank in the same cycle SHALL both take effect.
REQ-027 A bank freed at edge N SHALL show in_ready=1 from cycle N+1, with no same-cycle reuse.
REQ-028 A write SHALL never target the bank being read, since wr_sel == rd_sel only when that bank is empty.
REQ-029 Latency SHALL be first slice valid 1 cycle after input acceptance.
REQ-030 Throughput SHALL be 1 slice per cycle sustained, provided in_valid is offered at least once every RATIO cycles.
REQ-031 occupancy SHALL equal full[0] + full[1].
REQ-032 flush=1 SHALL, at the next edge, clear both full flags, wr_sel, rd_sel and cnt, and SHALL override any simultaneous input or output transfer.
REQ-033 Bank contents need not be cleared by flush.
REQ-034 cnt SHALL wrap to 0 only via REQ-024 and SHALL never exceed RATIO-1.

Reset
REQ-035 On rst_n=0 the block SHALL asynchronously clear both full flags, wr_sel, rd_sel and cnt, and clear both banks to 0.
REQ-036 During reset, outputs SHALL be in_ready=1, out_valid=0, out_last=0, occupancy=0 and out_data=0.
REQ-037 Assertion of rst_n mid-word SHALL discard all partially read data; after release the block SHALL resume as after power-up.

Verification
REQ-038 Single word, defaults, out_ready=1: in_data=128'h44444444_33333333_22222222_11111111 -> out_data 11111111, 22222222, 33333333, 44444444 on 4 consecutive cycles, out_last on the 4th beat, then out_valid=0.
REQ-039 MSB_FIRST=1, same word -> slice order 44444444, 33333333, 22222222, 11111111.
REQ-040 Back-to-back words A and B, out_ready=0 -> occupancy=2 and in_ready=0; a third word C is held off; releasing out_ready -> 8 slices A then B with no gap, and C is accepted in the cycle after A's last slice.
REQ-041 out_ready toggling 1,0,1,0 -> each slice is held while stalled; no slice is lost or duplicated; cnt reaches 3 only on the 4th accepted beat.
REQ-042 flush asserted after 2 slices of A with B buffered -> next cycle occupancy=0, out_valid=0, in_ready=1; a new word D then outputs starting at its slice 0.
REQ-043 rst_n pulsed low during the 3rd slice -> outputs take reset values immediately; after release, a new word streams correctly from slice 0.
